// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the issue-stage hazard scoreboard.
// Default geometry and the branch opcodes the decoder flags as issue_branch.
package hazard_scoreboard_pkg;

  localparam int SB_NREG   = 32;
  localparam int SB_RW     = 5;
  localparam int SB_MAXLAT = 7;
  localparam int SB_BRPEN  = 1;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register result countdown for the hazard scoreboard.
// A load from a firing writer overrides the per-cycle decrement.
module sb_counter #(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          busy
);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = cnt_q != '0;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage scoreboard: RAW/WAW/branch-shadow stall generation.
// Register 0 is hardwired, so it never owns a counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = SB_NREG,
  parameter int RW     = SB_RW,
  parameter int MAXLAT = SB_MAXLAT,
  parameter int BRPEN  = SB_BRPEN,
  localparam int CW    = $clog2(MAXLAT + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rs,
  input  logic [RW-1:0]   issue_rt,
  input  logic            use_rs,
  input  logic            use_rt,
  input  logic            issue_wen,
  input  logic [RW-1:0]   issue_rd,
  input  logic [CW-1:0]   issue_lat,
  input  logic            issue_branch,
  input  logic            flush,
  output logic            stall,
  output logic            issue_fire,
  output logic [NREG-1:0] busy_mask,
  output logic [RW:0]     pending_cnt
);

  localparam int BW = (BRPEN > 0) ? $clog2(BRPEN + 1) : 1;
  localparam logic [CW-1:0] MAX_L  = CW'(MAXLAT);
  localparam logic [BW-1:0] BR_LD  = BW'(BRPEN);

  logic [NREG-1:0][CW-1:0] cnt;
  logic [CW-1:0]           lat_eff;
  logic                    raw;
  logic                    waw;
  logic                    brblk;
  logic                    wr_load;
  logic [BW-1:0]           br_cnt_d;
  logic [BW-1:0]           br_cnt_q;

  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(
      .CW(CW)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .load    (wr_load && (issue_rd == RW'(r))),
      .load_val(lat_eff),
      .cnt     (cnt[r]),
      .busy    (busy_mask[r])
    );
  end

  // Hazards look only at pre-issue counts, so rd==rs never self-blocks.
  always_comb begin
    lat_eff = (issue_lat > MAX_L) ? MAX_L : issue_lat;
    raw = (use_rs && issue_rs != '0 && cnt[issue_rs] != '0)
       || (use_rt && issue_rt != '0 && cnt[issue_rt] != '0);
    waw = issue_wen && issue_rd != '0
       && (cnt[issue_rd] > lat_eff);
    brblk      = br_cnt_q != '0;
    stall      = issue_valid && !flush && (raw || waw || brblk);
    issue_fire = issue_valid && !flush && !stall;
    wr_load    = issue_fire && issue_wen && issue_rd != '0;
  end

  always_comb begin
    br_cnt_d = br_cnt_q;
    if (flush) begin
      br_cnt_d = '0;
    end else if (issue_fire && issue_branch) begin
      br_cnt_d = BR_LD;
    end else if (br_cnt_q != '0) begin
      br_cnt_d = br_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      br_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      pending_cnt = pending_cnt + (RW+1)'(busy_mask[i]);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic.
// Model tracks the absolute cycle at which each result becomes ready.
module tb_hazard_scoreboard;

  localparam int NREG     = 32;
  localparam int RW       = 5;
  localparam int MAXLAT   = 7;
  localparam int MAXLAT_B = 5;
  localparam int BRPEN    = 1;
  localparam int CW       = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [RW-1:0] issue_rs;
  logic [RW-1:0] issue_rt;
  logic          use_rs;
  logic          use_rt;
  logic          issue_wen;
  logic [RW-1:0] issue_rd;
  logic [CW-1:0] issue_lat;
  logic          issue_branch;
  logic          flush;

  logic            stall_a, fire_a;
  logic [NREG-1:0] busy_a;
  logic [RW:0]     pend_a;
  logic            stall_b, fire_b;
  logic [NREG-1:0] busy_b;
  logic [RW:0]     pend_b;

  int checks   = 0;
  int failures = 0;

  longint now;
  longint ready [2][NREG];
  longint bru [2];

  logic            obs_stall, obs_fire;
  logic [NREG-1:0] obs_busy, obs_busy_b;
  logic [RW:0]     obs_pend;

  always #5 clock = ~clock;

  hazard_scoreboard #(
    .NREG(NREG), .RW(RW), .MAXLAT(MAXLAT), .BRPEN(BRPEN)
  ) dut_a (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .use_rs(use_rs), .use_rt(use_rt),
    .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_lat(issue_lat),
    .issue_branch(issue_branch), .flush(flush),
    .stall(stall_a), .issue_fire(fire_a),
    .busy_mask(busy_a), .pending_cnt(pend_a)
  );

  hazard_scoreboard #(
    .NREG(NREG), .RW(RW), .MAXLAT(MAXLAT_B), .BRPEN(BRPEN)
  ) dut_b (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .use_rs(use_rs), .use_rt(use_rt),
    .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_lat(issue_lat),
    .issue_branch(issue_branch), .flush(flush),
    .stall(stall_b), .issue_fire(fire_b),
    .busy_mask(busy_b), .pending_cnt(pend_b)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_rs     = '0;
    issue_rt     = '0;
    use_rs       = 1'b0;
    use_rt       = 1'b0;
    issue_wen    = 1'b0;
    issue_rd     = '0;
    issue_lat    = '0;
    issue_branch = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic set_issue(input int rs, input int rt,
                           input bit urs, input bit urt,
                           input bit wen, input int rd,
                           input int lat, input bit br);
    issue_valid  = 1'b1;
    issue_rs     = RW'(rs);
    issue_rt     = RW'(rt);
    use_rs       = urs;
    use_rt       = urt;
    issue_wen    = wen;
    issue_rd     = RW'(rd);
    issue_lat    = CW'(lat);
    issue_branch = br;
    flush        = 1'b0;
  endtask

  // Check both DUTs against the model, then advance one clock.
  task automatic tick();
    bit st [2];
    bit fi [2];
    int le [2];
    int ml, pc;
    bit raw, waw, brb;
    longint rem;
    logic [NREG-1:0] bm;
    string nm;
    #1;
    for (int k = 0; k < 2; k++) begin
      ml = (k == 0) ? MAXLAT : MAXLAT_B;
      le[k] = (int'(issue_lat) > ml) ? ml : int'(issue_lat);
      raw = (use_rs && issue_rs != 0
             && ready[k][issue_rs] > now)
         || (use_rt && issue_rt != 0
             && ready[k][issue_rt] > now);
      rem = ready[k][issue_rd] - now;
      if (rem < 0) rem = 0;
      waw = issue_wen && issue_rd != 0 && rem > le[k];
      brb = bru[k] > now;
      st[k] = issue_valid && !flush && (raw || waw || brb);
      fi[k] = issue_valid && !flush && !st[k];
      bm = '0;
      pc = 0;
      for (int r = 1; r < NREG; r++) begin
        if (ready[k][r] > now) begin
          bm[r] = 1'b1;
          pc++;
        end
      end
      nm = (k == 0) ? "A" : "B";
      if (k == 0) begin
        check({nm, ".stall"}, 64'(stall_a), 64'(st[k]));
        check({nm, ".fire"}, 64'(fire_a), 64'(fi[k]));
        check({nm, ".busy"}, 64'(busy_a), 64'(bm));
        check({nm, ".pend"}, 64'(pend_a), 64'(pc));
      end else begin
        check({nm, ".stall"}, 64'(stall_b), 64'(st[k]));
        check({nm, ".fire"}, 64'(fire_b), 64'(fi[k]));
        check({nm, ".busy"}, 64'(busy_b), 64'(bm));
        check({nm, ".pend"}, 64'(pend_b), 64'(pc));
      end
    end
    obs_stall  = stall_a;
    obs_fire   = fire_a;
    obs_busy   = busy_a;
    obs_busy_b = busy_b;
    obs_pend   = pend_a;
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int r = 0; r < NREG; r++) ready[k][r] = 0;
        bru[k] = 0;
      end else begin
        if (fi[k] && issue_wen && issue_rd != 0)
          ready[k][issue_rd] = now + le[k] + 1;
        if (flush)
          bru[k] = 0;
        else if (fi[k] && issue_branch)
          bru[k] = now + BRPEN + 1;
      end
    end
    now++;
    @(negedge clock);
  endtask

  task automatic run_until_fire(output int stalls,
                                output bit ok);
    stalls = 0;
    ok     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (obs_fire) begin
        ok = 1'b1;
        break;
      end
      if (obs_stall) stalls++;
    end
    idle();
  endtask

  task automatic count_busy(input int r,
                            output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (obs_busy[r])   na++;
      if (obs_busy_b[r]) nb++;
    end
  endtask

  int  ns, na, nb;
  bit  ok;

  initial begin
    now = 0;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NREG; r++) ready[k][r] = 0;
      bru[k] = 0;
    end
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tick();
    reset = 1'b0;
    tick();

    // load-use
    set_issue(0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    check("lu_writer_fire", 64'(obs_fire), 64'd1);
    set_issue(5, 0, 1, 0, 1, 6, 0, 0);
    run_until_fire(ns, ok);
    check("lu_stalls", 64'(ns), 64'd1);
    check("lu_fired", 64'(ok), 64'd1);
    set_issue(0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    idle();
    count_busy(5, na, nb);
    check("lu_busy_len", 64'(na), 64'd1);

    // multi-cycle
    set_issue(0, 0, 0, 0, 1, 3, 4, 0);
    tick();
    idle();
    tick();
    check("mc_pend1", 64'(obs_pend), 64'd1);
    set_issue(0, 3, 0, 1, 0, 0, 0, 0);
    run_until_fire(ns, ok);
    check("mc_stalls", 64'(ns), 64'd3);
    check("mc_fired", 64'(ok), 64'd1);
    tick();
    check("mc_pend0", 64'(obs_pend), 64'd0);
    set_issue(0, 0, 0, 0, 1, 3, 4, 0);
    tick();
    set_issue(3, 0, 1, 0, 0, 0, 0, 0);
    run_until_fire(ns, ok);
    check("mc_stalls4", 64'(ns), 64'd4);

    // WAW
    repeat (8) tick();
    set_issue(0, 0, 0, 0, 1, 7, 6, 0);
    tick();
    set_issue(0, 0, 0, 0, 1, 7, 2, 0);
    run_until_fire(ns, ok);
    check("waw_stalls", 64'(ns), 64'd4);
    check("waw_fired", 64'(ok), 64'd1);

    // self-dependency: rd == rs on a free register
    repeat (8) tick();
    set_issue(8, 8, 1, 1, 1, 8, 3, 0);
    tick();
    check("self_fire", 64'(obs_fire), 64'd1);

    // branch shadow and flush
    repeat (8) tick();
    set_issue(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("br_fire", 64'(obs_fire), 64'd1);
    set_issue(1, 2, 1, 1, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    check("fl_stall", 64'(obs_stall), 64'd0);
    check("fl_fire", 64'(obs_fire), 64'd0);
    flush = 1'b0;
    tick();
    check("fl_after_fire", 64'(obs_fire), 64'd1);
    set_issue(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_issue(1, 2, 1, 1, 0, 0, 0, 0);
    tick();
    check("br_stall", 64'(obs_stall), 64'd1);
    tick();
    check("br_release", 64'(obs_fire), 64'd1);
    idle();

    // r0 and saturation
    set_issue(0, 0, 0, 0, 1, 0, 5, 0);
    tick();
    idle();
    count_busy(0, na, nb);
    check("r0_busy", 64'(na + nb), 64'd0);
    set_issue(0, 0, 0, 0, 1, 9, 7, 0);
    tick();
    idle();
    count_busy(9, na, nb);
    check("sat_a_len", 64'(na), 64'd7);
    check("sat_b_len", 64'(nb), 64'd5);

    // reset with three registers busy
    set_issue(0, 0, 0, 0, 1, 1, 7, 0);
    tick();
    set_issue(0, 0, 0, 0, 1, 2, 7, 0);
    tick();
    set_issue(0, 0, 0, 0, 1, 4, 7, 0);
    tick();
    idle();
    reset = 1'b1;
    set_issue(1, 0, 1, 0, 1, 6, 3, 1);
    tick();
    check("rst_pend_pre", 64'(obs_pend), 64'd3);
    reset = 1'b0;
    idle();
    tick();
    check("rst_pend", 64'(obs_pend), 64'd0);
    check("rst_busy", 64'(obs_busy), 64'd0);
    check("rst_stall", 64'(obs_stall), 64'd0);

    // random traffic over a small register window
    for (int i = 0; i < 2500; i++) begin
      issue_valid  = ($urandom_range(0, 9) != 0);
      issue_rs     = RW'($urandom_range(0, 7));
      issue_rt     = RW'($urandom_range(0, 7));
      use_rs       = $urandom_range(0, 1) != 0;
      use_rt       = $urandom_range(0, 1) != 0;
      issue_wen    = $urandom_range(0, 3) != 0;
      issue_rd     = RW'($urandom_range(0, 7));
      issue_lat    = CW'($urandom_range(0, 7));
      issue_branch = $urandom_range(0, 7) == 0;
      flush        = $urandom_range(0, 9) == 0;
      reset        = $urandom_range(0, 199) == 0;
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
